alu_share_ctrl: RTL and testbench

ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

---
 rtl/alu_share_ctrl.sv | 123 ++++++++++++
 tb/tb_alu_share_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Two-requester arbiter in front of one shared 4-bit ALU.
// Ports: clk/rst, req0_*/req1_* (valid, a, b, op, ready), resp_* (valid, ready,
// id, result, cout, zero, err), ops_done (completed-response counter).
module alu_share_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   input  logic [2:0] req0_op,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   input  logic [2:0] req1_op,
   output logic       req1_ready,
   output logic       resp_valid,
   input  logic       resp_ready,
   output logic       resp_id,
   output logic [3:0] resp_result,
   output logic       resp_cout,
   output logic       resp_zero,
   output logic       resp_err,
   output logic [7:0] ops_done
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t     state;
   state_t     state_nx;

   // 1 when requester 1 held the most recent grant, so requester 0
   // wins the next contention.
   logic       last;
   logic       gnt0;
   logic       gnt1;

   logic [3:0] a_q;
   logic [3:0] b_q;
   logic [2:0] op_q;
   logic       id_q;

   logic [4:0] alu;
   logic       alu_err;

   always_comb begin
      state_nx = state;
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      unique case (state)
         IDLE: begin
            if (!rst) begin
               if (req0_valid && (!req1_valid || last))
                  gnt0 = 1'b1;
               else if (req1_valid)
                  gnt1 = 1'b1;
            end
            if (gnt0 || gnt1)
               state_nx = EXEC;
         end
         EXEC: state_nx = RESP;
         RESP: begin
            if (resp_ready)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign resp_valid = (state == RESP);

   // Bit 4 is the carry for add and the borrow for sub.
   always_comb begin
      alu     = 5'd0;
      alu_err = 1'b0;
      case (op_q)
         3'b000: alu = {1'b0, a_q} + {1'b0, b_q};
         3'b001: alu = {1'b0, a_q} - {1'b0, b_q};
         3'b010: alu = {1'b0, a_q & b_q};
         3'b011: alu = {1'b0, a_q | b_q};
         3'b100: alu = {1'b0, a_q ^ b_q};
         default: alu_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         last        <= 1'b1;
         resp_id     <= 1'b0;
         resp_result <= 4'd0;
         resp_cout   <= 1'b0;
         resp_zero   <= 1'b0;
         resp_err    <= 1'b0;
         ops_done    <= 8'd0;
      end else begin
         state <= state_nx;
         if (gnt0 || gnt1) begin
            a_q  <= gnt1 ? req1_a  : req0_a;
            b_q  <= gnt1 ? req1_b  : req0_b;
            op_q <= gnt1 ? req1_op : req0_op;
            id_q <= gnt1;
            last <= gnt1;
         end
         if (state == EXEC) begin
            resp_id     <= id_q;
            resp_result <= alu[3:0];
            resp_cout   <= alu[4];
            resp_zero   <= (alu[3:0] == 4'd0);
            resp_err    <= alu_err;
         end
         if (state == RESP && resp_ready)
            ops_done <= ops_done + 8'd1;
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: directed cases, contention,
// backpressure, reset mid-operation, then randomized traffic.
module tb_alu_share_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       v   [2];
   logic [3:0] ta  [2];
   logic [3:0] tb_ [2];
   logic [2:0] top [2];
   logic       req0_ready;
   logic       req1_ready;
   logic       resp_valid;
   logic       resp_ready = 1'b1;
   logic       resp_id;
   logic [3:0] resp_result;
   logic       resp_cout;
   logic       resp_zero;
   logic       resp_err;
   logic [7:0] ops_done;

   always #5 clk = ~clk;

   alu_share_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (v[0]),
      .req0_a     (ta[0]),
      .req0_b     (tb_[0]),
      .req0_op    (top[0]),
      .req0_ready (req0_ready),
      .req1_valid (v[1]),
      .req1_a     (ta[1]),
      .req1_b     (tb_[1]),
      .req1_op    (top[1]),
      .req1_ready (req1_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_result(resp_result),
      .resp_cout  (resp_cout),
      .resp_zero  (resp_zero),
      .resp_err   (resp_err),
      .ops_done   (ops_done)
   );

   int checks   = 0;
   int failures = 0;

   // Packed response: {id, result[3:0], cout, zero, err}
   logic [7:0] sb_q [$];
   logic [7:0] hist [$];
   int         grants [$];
   logic       busy   = 1'b0;
   logic       m_last = 1'b1;
   int         m_ops  = 0;
   int         cyc    = 0;
   int         acc_cyc = 0;
   logic       acc [2];
   int         rate [2];
   logic       rr_rand = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] model(input logic id,
                                        input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic [2:0] op);
      int r;
      int c;
      int e;
      r = 0;
      c = 0;
      e = 0;
      case (op)
         3'd0: begin
            r = (int'(a) + int'(b)) % 16;
            c = (int'(a) + int'(b) > 15) ? 1 : 0;
         end
         3'd1: begin
            r = (int'(a) - int'(b) + 16) % 16;
            c = (a < b) ? 1 : 0;
         end
         3'd2: r = int'(a & b);
         3'd3: r = int'(a | b);
         3'd4: r = int'(a ^ b);
         default: e = 1;
      endcase
      return {id, 4'(r), c[0], (r == 0), e[0]};
   endfunction

   // Monitor / reference model, sampled on the falling edge.
   always @(negedge clk) begin
      logic e0;
      logic e1;
      logic [7:0] got;
      e0 = 1'b0;
      e1 = 1'b0;
      if (rst) begin
         chk("ready0_in_rst", req0_ready, 0);
         chk("ready1_in_rst", req1_ready, 0);
         sb_q.delete();
         busy   = 1'b0;
         m_last = 1'b1;
         m_ops  = 0;
      end else begin
         chk("ops_done", ops_done, m_ops % 256);
         if (!busy) begin
            if (v[0] && v[1]) begin
               e0 = m_last;
               e1 = !m_last;
            end else begin
               e0 = v[0];
               e1 = v[1];
            end
         end
         chk("ready0", req0_ready, e0);
         chk("ready1", req1_ready, e1);
         if (e0 || e1) begin
            sb_q.push_back(model(e1, ta[e1], tb_[e1], top[e1]));
            m_last = e1;
            busy   = 1'b1;
            acc_cyc = cyc;
            acc[e1] = 1'b1;
            grants.push_back(e1 ? 1 : 0);
         end
         chk("resp_valid", resp_valid,
             (busy && cyc - acc_cyc >= 2) ? 1 : 0);
         if (resp_valid && sb_q.size() > 0) begin
            got = {resp_id, resp_result, resp_cout,
                   resp_zero, resp_err};
            chk("resp_fields", got, sb_q[0]);
            if (resp_ready) begin
               hist.push_back(got);
               void'(sb_q.pop_front());
               m_ops++;
               busy = 1'b0;
            end
         end
      end
      cyc++;
   end

   task automatic drv(input int n);
      forever begin
         @(posedge clk);
         #1;
         if (acc[n]) begin
            acc[n] = 1'b0;
            v[n]   = 1'b0;
         end
         if (!v[n] && rate[n] > 0 &&
             $urandom_range(1, 100) <= rate[n]) begin
            ta[n]  = 4'($urandom);
            tb_[n] = 4'($urandom);
            top[n] = 3'($urandom_range(0, 7));
            v[n]   = 1'b1;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rr_rand)
            resp_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic issue(input int n, input logic [3:0] a,
                        input logic [3:0] b, input logic [2:0] op);
      @(posedge clk);
      #1;
      ta[n]  = a;
      tb_[n] = b;
      top[n] = op;
      v[n]   = 1'b1;
   endtask

   task automatic wait_idle(input string nm, input int lim);
      int k;
      k = 0;
      while (busy || v[0] || v[1] || sb_q.size() != 0) begin
         @(negedge clk);
         k++;
         if (k > lim) begin
            chk({nm, "_timeout"}, k, lim);
            return;
         end
      end
   endtask

   initial begin
      int k;
      int g0;
      int o0;
      v[0] = 1'b0;
      v[1] = 1'b0;
      acc[0] = 1'b0;
      acc[1] = 1'b0;
      rate[0] = 0;
      rate[1] = 0;
      ta[0] = 4'd0; ta[1] = 4'd0;
      tb_[0] = 4'd0; tb_[1] = 4'd0;
      top[0] = 3'd0; top[1] = 3'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_ops_done", ops_done, 0);
      chk("rst_resp_vec",
          {resp_id, resp_result, resp_cout, resp_zero, resp_err}, 0);

      // add with carry and zero result
      issue(0, 4'b0111, 4'b1001, 3'b000);
      wait_idle("add", 20);
      chk("add_resp", hist[$], {1'b0, 4'b0000, 1'b1, 1'b1, 1'b0});
      @(negedge clk);
      chk("add_ops_done", ops_done, 1);

      // sub with borrow
      issue(1, 4'b0011, 4'b0101, 3'b001);
      wait_idle("sub", 20);
      chk("sub_resp", hist[$], {1'b1, 4'b1110, 1'b1, 1'b0, 1'b0});

      // reserved opcode
      issue(0, 4'b1111, 4'b1111, 3'b110);
      wait_idle("rsv", 20);
      chk("rsv_resp", hist[$], {1'b0, 4'b0000, 1'b0, 1'b1, 1'b1});

      // backpressure with a second request waiting
      resp_ready = 1'b0;
      issue(0, 4'd5, 4'd3, 3'b000);
      k = 0;
      while (!busy && k < 20) begin
         @(negedge clk);
         k++;
      end
      issue(1, 4'd9, 4'd9, 3'b100);
      k = 0;
      while (!resp_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("bp_reached_resp", resp_valid, 1);
      o0 = ops_done;
      repeat (3) @(negedge clk);
      chk("bp_ops_held", ops_done, o0);
      chk("bp_resp_held", {resp_id, resp_result}, {1'b0, 4'd8});
      @(posedge clk);
      #1 resp_ready = 1'b1;
      wait_idle("bp", 30);
      chk("bp_first", hist[$-1], {1'b0, 4'b1000, 1'b0, 1'b0, 1'b0});
      chk("bp_second", hist[$], {1'b1, 4'b0000, 1'b0, 1'b1, 1'b0});

      // reset while an operation is in EXEC
      issue(1, 4'd2, 4'd2, 3'b000);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!req1_ready && k < 20);
      chk("mid_accept", req1_ready, 1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      #1;
      chk("mid_resp_valid", resp_valid, 0);
      chk("mid_ops_done", ops_done, 0);

      // continuous contention: grants must alternate from requester 0
      g0 = grants.size();
      @(posedge clk);
      #1;
      ta[0] = 4'd1; tb_[0] = 4'd2; top[0] = 3'd0;
      ta[1] = 4'd7; tb_[1] = 4'd4; top[1] = 3'd1;
      v[0] = 1'b1;
      v[1] = 1'b1;
      rate[0] = 100;
      rate[1] = 100;
      k = 0;
      while (grants.size() < g0 + 4 && k < 100) begin
         @(negedge clk);
         k++;
      end
      rate[0] = 0;
      rate[1] = 0;
      if (grants.size() < g0 + 4) begin
         chk("cont_timeout", grants.size() - g0, 4);
      end else begin
         for (int i = 0; i < 4; i++)
            chk("cont_grant", grants[g0 + i], i % 2);
      end
      wait_idle("cont", 40);

      // randomized traffic with random backpressure
      rate[0] = 50;
      rate[1] = 40;
      rr_rand = 1'b1;
      repeat (800) @(posedge clk);
      rate[0] = 0;
      rate[1] = 0;
      @(posedge clk);
      rr_rand = 1'b0;
      #1 resp_ready = 1'b1;
      wait_idle("rand", 50);
      @(negedge clk);
      chk("final_ops_done", ops_done, m_ops % 256);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      fork
         drv(0);
         drv(1);
      join_none
   end

endmodule
